// File: rtl/booth_mult_seq_if.sv
// Operand/result handshake bundle for the sequential Booth multiplier.
// The master drives the request, the slave (multiplier) returns status and result.
interface booth_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic                 shr_o;
  logic                 dump_o;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product, shr_o, dump_o
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product, shr_o, dump_o
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock over an
// {A,Q,q_1} shift register, registered product with a one-cycle done pulse.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  booth_mult_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DUMP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  // A and M carry one guard bit so A-M cannot overflow when M is most negative
  logic signed [WIDTH:0] r_a;
  logic signed [WIDTH:0] r_m;
  logic signed [WIDTH:0] w_a_sum;
  logic [WIDTH-1:0]      r_q;
  logic                  r_q1;
  logic [CW-1:0]         r_cnt;
  logic [2*WIDTH-1:0]    r_product;
  logic                  r_done;

  logic                  w_busy;
  logic                  w_shr;
  logic                  w_dump;
  logic                  w_last;

  assign w_last = (r_cnt == CW'(1));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state logic; start is only looked at in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DUMP;
      S_DUMP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // output decode, purely from the state register
  always_comb begin
    w_busy = 1'b0;
    w_shr  = 1'b0;
    w_dump = 1'b0;
    case (r_state)
      S_RUN:   begin w_busy = 1'b1; w_shr  = 1'b1; end
      S_DUMP:  begin w_busy = 1'b1; w_dump = 1'b1; end
      default: ;
    endcase
  end

  // Booth recode of {Q[0], q_1}
  always_comb begin
    w_a_sum = r_a;
    case ({r_q[0], r_q1})
      2'b01:   w_a_sum = r_a + r_m;
      2'b10:   w_a_sum = r_a - r_m;
      default: w_a_sum = r_a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_m   <= '0;
      r_q   <= '0;
      r_q1  <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_m   <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
          r_q   <= bus.multiplier;
          r_a   <= '0;
          r_q1  <= 1'b0;
          r_cnt <= CW'(WIDTH);
        end
        S_RUN: begin
          // arithmetic shift of {A',Q,q_1} by one
          r_a   <= {w_a_sum[WIDTH], w_a_sum[WIDTH:1]};
          r_q   <= {w_a_sum[0], r_q[WIDTH-1:1]};
          r_q1  <= r_q[0];
          r_cnt <= r_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == S_DUMP);
      if (r_state == S_DUMP) r_product <= {r_a[WIDTH-1:0], r_q};
    end
  end

  assign bus.busy    = w_busy;
  assign bus.shr_o   = w_shr;
  assign bus.dump_o  = w_dump;
  assign bus.done    = r_done;
  assign bus.product = r_product;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq at WIDTH=8 (directed) and WIDTH=4 (exhaustive).
module tb_booth_mult_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_mult_seq_if #(.WIDTH(8)) bus8 ();
  booth_mult_seq_if #(.WIDTH(4)) bus4 ();

  booth_mult_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  booth_mult_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  int checks = 0;
  int errors = 0;
  logic [15:0] sb8[$];
  logic [7:0]  sb4[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus8.start = 1'b0; bus8.multiplicand = '0; bus8.multiplier = '0;
    bus4.start = 1'b0; bus4.multiplicand = '0; bus4.multiplier = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus8.busy, bus8.done, bus8.shr_o, bus8.dump_o} !== 4'b0 || bus8.product !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b shr=%b dump=%b product=%h, want all 0",
               bus8.busy, bus8.done, bus8.shr_o, bus8.dump_o, bus8.product);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  // drive one WIDTH=8 operation, check latency, strobes and product
  task automatic mult8(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp);
    int lat, n_shr, n_dump;
    logic [15:0] e;
    sb8.push_back(exp);
    bus8.multiplicand = m; bus8.multiplier = q; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0; bus8.multiplicand = 8'hxx; bus8.multiplier = 8'hxx;
    checks++;
    if (bus8.busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_accept: got %b want 1", bus8.busy);
    end
    lat = 0; n_shr = 0; n_dump = 0;
    while (lat < 30) begin
      n_shr  += int'(bus8.shr_o);
      n_dump += int'(bus8.dump_o);
      tick(); lat++;
      if (bus8.done === 1'b1) break;
    end
    e = sb8.pop_front();
    checks++;
    if (bus8.done !== 1'b1) begin
      errors++; $display("FAIL timeout8: no done for %0d*%0d", $signed(m), $signed(q));
    end else begin
      checks += 3;
      if (bus8.product !== e) begin
        errors++; $display("FAIL product8 %0d*%0d: got %h want %h", $signed(m), $signed(q), bus8.product, e);
      end
      if (lat != 9) begin
        errors++; $display("FAIL latency8: got %0d want 9", lat);
      end
      if (n_shr != 8 || n_dump != 1) begin
        errors++; $display("FAIL strobes8: shr=%0d dump=%0d want 8/1", n_shr, n_dump);
      end
    end
  endtask

  task automatic test_basic();
    mult8(8'd3, -8'sd4, 16'hFFF4);
  endtask

  task automatic test_corners();
    mult8(8'h80, 8'h80, 16'h4000);
    mult8(8'h7F, 8'h80, 16'hC080);
    mult8(8'h80, 8'h01, 16'hFF80);
  endtask

  task automatic test_back_to_back();
    int lat, gap;
    sb8.push_back(16'h001E);
    sb8.push_back(16'hFFC1);
    bus8.multiplicand = 8'd5; bus8.multiplier = 8'd6; bus8.start = 1'b1;
    tick();
    lat = 0;
    while (lat < 30) begin
      if (lat == 3) begin bus8.multiplicand = -8'sd7; bus8.multiplier = 8'd9; end
      tick(); lat++;
      if (bus8.done === 1'b1) break;
    end
    checks += 3;
    if (bus8.product !== sb8.pop_front() || bus8.done !== 1'b1) begin
      errors++; $display("FAIL b2b_first: product=%h done=%b want 001e/1", bus8.product, bus8.done);
    end
    if (lat != 9) begin
      errors++; $display("FAIL b2b_first_latency: got %0d want 9", lat);
    end
    if (bus8.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_no_accept_in_dump: busy=%b want 0", bus8.busy);
    end
    gap = 0;
    while (gap < 30) begin
      tick(); gap++;
      if (gap == 1) begin
        checks++;
        if (bus8.busy !== 1'b1) begin
          errors++; $display("FAIL b2b_second_accept: busy=%b want 1", bus8.busy);
        end
        bus8.start = 1'b0;
      end
      if (bus8.done === 1'b1) break;
    end
    checks += 2;
    if (bus8.product !== sb8.pop_front() || bus8.done !== 1'b1) begin
      errors++; $display("FAIL b2b_second: product=%h done=%b want ffc1/1", bus8.product, bus8.done);
    end
    if (gap != 10) begin
      errors++; $display("FAIL b2b_gap: got %0d want 10", gap);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    bus8.multiplicand = 8'd11; bus8.multiplier = 8'd13; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.busy, bus8.done, bus8.shr_o, bus8.dump_o} !== 4'b0 || bus8.product !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b shr=%b dump=%b product=%h, want all 0",
               bus8.busy, bus8.done, bus8.shr_o, bus8.dump_o, bus8.product);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    mult8(8'd2, 8'd3, 16'h0006);
  endtask

  task automatic test_product_hold();
    int bad;
    mult8(8'd0, 8'hFF, 16'h0000);
    mult8(8'hFF, 8'hFF, 16'h0001);
    bad = 0;
    repeat (20) begin
      tick();
      checks++;
      if (bus8.product !== 16'h0001 || bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL hold: product=%h done=%b busy=%b want 0001/0/0",
                              bus8.product, bus8.done, bus8.busy);
      end
    end
  endtask

  task automatic test_exhaustive4();
    int lat, shown;
    logic [7:0] e;
    logic signed [7:0] ref_p;
    shown = 0;
    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        ref_p = 8'(a * b);
        sb4.push_back(ref_p);
        bus4.multiplicand = 4'(a); bus4.multiplier = 4'(b); bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        lat = 0;
        while (lat < 20) begin
          tick(); lat++;
          if (bus4.done === 1'b1) break;
        end
        e = sb4.pop_front();
        checks++;
        if (bus4.done !== 1'b1 || bus4.product !== e || lat != 5) begin
          errors++;
          if (shown < 8) $display("FAIL exh4 %0d*%0d: product=%h lat=%0d want %h lat 5",
                                  a, b, bus4.product, lat, e);
          shown++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_reset_mid_run();
    test_product_hold();
    test_exhaustive4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
